coprocessor_rodata_arbiter: RTL and testbench
=============================================

# coprocessor_rodata_arbiter

Two-port arbiter in front of the RISC-V coprocessor's 5120×32 read-only-data RAM. It shares the single RAM port between two requesters. The host port (Nios, Avalon-MM, read/write) loads and inspects contents. The core port (RISC-V load unit, read-only) fetches constants. The block issues at most one RAM access per cycle, returns read data with fixed latency, filters out-of-range addresses and counts core stall cycles.

## Interface
- DEPTH, 5120: number of valid RAM words; addresses ≥ DEPTH are out of range.
- ADDR_W, 13: word-address width on all ports.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- clk  in  1  single clock for all logic and the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- host_address  in  ADDR_W  host word address.
- host_byteenable  in  4  host write byte lanes.
- host_read / host_write  in  1 each  host request strobes; both high is treated as a write.
- host_writedata  in  32  host write data.
- host_lock  in  1  when high, the core is never granted (bulk-load mode).
- host_waitrequest  out  1  Avalon waitrequest for the host.
- host_readdatavalid  out  1  host read data valid.
- host_readdata  out  32  host read data.
- core_address  in  ADDR_W  core word address.
- core_read  in  1  core read request.
- core_waitrequest / core_readdatavalid  out  1 each  handshake for the core.
- core_readdata  out  32  core read data.
- ram_address  out  ADDR_W; ram_byteenable  out  4; ram_chipselect  out  1; ram_write  out  1; ram_debugaccess  out  1; ram_writedata  out  32; ram_clken  out  1  RAM port drive.
- ram_readdata  in  32  RAM q, valid the cycle after the RAM samples the address.
- err_clear  in  1  clears err_oor.
- err_oor  out  1  sticky out-of-range flag.
- core_stall_cnt  out  16  saturating count of core stall cycles.

## Operation
- Request: host_req = host_read|host_write; core_req = core_read.
- Grant each cycle:
  - host_lock=1: host only.
  - Exactly one requester: that requester.
  - Both requesting: the requester not granted last (round-robin on last_grant).
- last_grant updates on every grant. Its reset value is HOST, so the core wins the first conflict.
- The granted port sees waitrequest=0 in that cycle; the accept happens at the next rising edge. The ungranted requesting port sees waitrequest=1.
- In-range grant drives:
  - ram_chipselect=1 and ram_address = granted address.
  - For a host write: ram_write=1, ram_debugaccess=1, writedata and byteenable pass through.
  - For a core read: ram_byteenable=4'hF.
- Out-of-range grant (address ≥ DEPTH):
  - Still accepted, with ram_chipselect=0.
  - A read returns 0x00000000 with readdatavalid.
  - err_oor is set for both reads and writes.
- err_oor: set and err_clear in the same cycle leaves it set.
- ram_clken is tied high. There is no read-during-write forwarding, since only one access occurs per cycle.
- core_stall_cnt increments every cycle with core_read=1 and core_waitrequest=1, and saturates at 0xFFFF. It is cleared only by reset.
- Toggling host_lock takes effect on the next grant decision. An already-accepted core read still returns its data.

## Timing
- Reset (asynchronous assert, synchronous release), all outputs:
  - waitrequest=1 on both ports.
  - readdatavalid=0 and readdata=0 on both ports.
  - ram_chipselect=0, ram_write=0, ram_debugaccess=0.
  - err_oor=0, core_stall_cnt=0, last_grant=HOST.
- Waitrequest is deasserted from the first cycle after reset release.
- Read latency: accepted at edge N → readdatavalid=1 and readdata valid during cycle N+1 (readdata = ram_readdata, or 0 if out of range). One pulse per accepted read.
- readdata is 0 whenever readdatavalid=0.
- Throughput: one access per cycle. Back-to-back accepts on the same port are allowed, so readdatavalid can be high on consecutive cycles.
- Writes have no response. The RAM updates at the accept edge.
- Reset asserted mid-read: the pending readdatavalid is dropped; no response is produced after release.
- Waitrequest is a combinational function of the requests, host_lock and last_grant. It has no path from ram_readdata.

## Test plan
- Host write 0xCAFEF00D to address 0x0010 with byteenable F, then host read 0x0010 → host_readdatavalid pulses one cycle after the accept with 0xCAFEF00D; the core port stays idle.
- Host and core both request continuously for 4 cycles, starting from reset → grants go core, host, core, host; each readdatavalid returns on the matching port; core_stall_cnt=2.
- host_lock=1 while the core reads for 10 cycles → core_waitrequest stays high; core_stall_cnt=10; host accesses proceed every cycle.
- Core read of address 5120 → readdatavalid with 0x00000000; ram_chipselect stays 0; err_oor=1. Assert err_clear alongside a new out-of-range access → err_oor stays 1. Assert err_clear alone → err_oor=0.
- Host partial write of 0x11223344 with byteenable 4'b0101 over an existing 0xFFFFFFFF → read returns 0xFF22FF44.
- Assert reset_n low one cycle after a core read is accepted → no core_readdatavalid after release; all outputs return to their reset values immediately.

Source files
------------

// File: rtl/coprocessor_rodata_arbiter.sv
// Shares the single port of the coprocessor read-only-data RAM between the host (Avalon-MM
// read/write) and the core load unit (read-only), one access per cycle, fixed read latency.
module coprocessor_rodata_arbiter #(
    parameter int unsigned DEPTH  = 5120,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     host_address,
    input  logic [DATA_W/8-1:0]   host_byteenable,
    input  logic                  host_read,
    input  logic                  host_write,
    input  logic [DATA_W-1:0]     host_writedata,
    input  logic                  host_lock,
    output logic                  host_waitrequest,
    output logic                  host_readdatavalid,
    output logic [DATA_W-1:0]     host_readdata,

    input  logic [ADDR_W-1:0]     core_address,
    input  logic                  core_read,
    output logic                  core_waitrequest,
    output logic                  core_readdatavalid,
    output logic [DATA_W-1:0]     core_readdata,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_debugaccess,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,

    input  logic                  err_clear,
    output logic                  err_oor,
    output logic [15:0]           core_stall_cnt
);

    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        GrantHost = 1'b0,
        GrantCore = 1'b1
    } grant_e;

    grant_e              last_grant_q;
    logic                ready_q;
    logic                rvalid_q;
    grant_e              rport_q;
    logic                roor_q;
    logic                err_q;
    logic [15:0]         stall_q;

    logic                host_req;
    logic                core_req;
    logic                gnt_host;
    logic                gnt_core;
    logic                accept;
    logic                acc_write;
    logic                acc_read;
    logic                in_range;
    logic [ADDR_W-1:0]   sel_addr;

    // Grant decision: lock forces host-only, conflicts alternate on last_grant.
    always_comb begin
        host_req = host_read | host_write;
        core_req = core_read;
        gnt_host = 1'b0;
        gnt_core = 1'b0;
        if (ready_q) begin
            if (host_lock) begin
                gnt_host = host_req;
            end else if (host_req && core_req) begin
                if (last_grant_q == GrantHost) begin
                    gnt_core = 1'b1;
                end else begin
                    gnt_host = 1'b1;
                end
            end else begin
                gnt_host = host_req;
                gnt_core = core_req;
            end
        end
    end

    always_comb begin
        host_waitrequest = ~ready_q | (host_req & ~gnt_host);
        core_waitrequest = ~ready_q | (core_req & ~gnt_core);

        accept    = gnt_host | gnt_core;
        acc_write = gnt_host & host_write;
        acc_read  = accept & ~acc_write;

        if (gnt_core) begin
            sel_addr = core_address;
        end else if (gnt_host) begin
            sel_addr = host_address;
        end else begin
            sel_addr = '0;
        end
        in_range = ({1'b0, sel_addr} < DepthLim);

        ram_address     = sel_addr;
        ram_chipselect  = accept & in_range;
        ram_write       = acc_write & in_range;
        ram_debugaccess = acc_write & in_range;
        ram_byteenable  = gnt_host ? host_byteenable : '1;
        ram_writedata   = host_writedata;
        ram_clken       = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            last_grant_q <= GrantHost;
            rvalid_q     <= 1'b0;
            rport_q      <= GrantHost;
            roor_q       <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= '0;
        end else begin
            ready_q  <= 1'b1;
            rvalid_q <= acc_read;
            if (accept) begin
                last_grant_q <= gnt_core ? GrantCore : GrantHost;
                rport_q      <= gnt_core ? GrantCore : GrantHost;
                roor_q       <= ~in_range;
            end
            // A new out-of-range access wins over a simultaneous clear.
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end else if (err_clear) begin
                err_q <= 1'b0;
            end
            if (core_read && core_waitrequest && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    always_comb begin
        host_readdatavalid = rvalid_q & (rport_q == GrantHost);
        core_readdatavalid = rvalid_q & (rport_q == GrantCore);
        host_readdata      = (host_readdatavalid && !roor_q) ? ram_readdata : '0;
        core_readdata      = (core_readdatavalid && !roor_q) ? ram_readdata : '0;
        err_oor            = err_q;
        core_stall_cnt     = stall_q;
    end

endmodule

// File: tb/tb_coprocessor_rodata_arbiter.sv
// Directed bench for coprocessor_rodata_arbiter: behavioural RAM, shadow memory model and
// per-port response scoreboards.
module tb_coprocessor_rodata_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [12:0] host_address;
    logic [3:0]  host_byteenable;
    logic        host_read;
    logic        host_write;
    logic [31:0] host_writedata;
    logic        host_lock;
    logic        host_waitrequest;
    logic        host_readdatavalid;
    logic [31:0] host_readdata;
    logic [12:0] core_address;
    logic        core_read;
    logic        core_waitrequest;
    logic        core_readdatavalid;
    logic [31:0] core_readdata;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic        ram_debugaccess;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;
    logic        err_clear;
    logic        err_oor;
    logic [15:0] core_stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] host_q[$];
    logic [31:0] core_q[$];
    logic [31:0] shadow [0:5119];
    logic [31:0] mem [0:5119];
    bit          mem_init;

    coprocessor_rodata_arbiter dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .host_address       (host_address),
        .host_byteenable    (host_byteenable),
        .host_read          (host_read),
        .host_write         (host_write),
        .host_writedata     (host_writedata),
        .host_lock          (host_lock),
        .host_waitrequest   (host_waitrequest),
        .host_readdatavalid (host_readdatavalid),
        .host_readdata      (host_readdata),
        .core_address       (core_address),
        .core_read          (core_read),
        .core_waitrequest   (core_waitrequest),
        .core_readdatavalid (core_readdatavalid),
        .core_readdata      (core_readdata),
        .ram_address        (ram_address),
        .ram_byteenable     (ram_byteenable),
        .ram_chipselect     (ram_chipselect),
        .ram_write          (ram_write),
        .ram_debugaccess    (ram_debugaccess),
        .ram_writedata      (ram_writedata),
        .ram_clken          (ram_clken),
        .ram_readdata       (ram_readdata),
        .err_clear          (err_clear),
        .err_oor            (err_oor),
        .core_stall_cnt     (core_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 ^ 32'(i * 7);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port synchronous RAM: q registered on every selected access.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 5120; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else if (ram_chipselect && ram_clken && (int'(ram_address) < 5120)) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) begin
                        mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                    end
                end
            end
            ram_readdata <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        host_read = 1'b0;
        host_write = 1'b0;
        core_read = 1'b0;
        host_lock = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_host_wait", host_waitrequest, 1'b1);
        chk("rst_core_wait", core_waitrequest, 1'b1);
        chk("rst_host_rvalid", host_readdatavalid, 1'b0);
        chk("rst_core_rvalid", core_readdatavalid, 1'b0);
        chk("rst_host_rdata", host_readdata, 32'h0);
        chk("rst_core_rdata", core_readdata, 32'h0);
        chk("rst_ram_cs", ram_chipselect, 1'b0);
        chk("rst_ram_write", ram_write, 1'b0);
        chk("rst_ram_debug", ram_debugaccess, 1'b0);
        chk("rst_err_oor", err_oor, 1'b0);
        chk("rst_stall", 32'(core_stall_cnt), 32'h0);
    endtask

    // Asserts reset at once, checks outputs, drops outstanding expectations, releases.
    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #1;
        check_reset_values();
        host_q.delete();
        core_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic host_acc(input bit wr, input logic [12:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        bit inr;
        inr = (int'(a) < 5120);
        host_read = ~wr;
        host_write = wr;
        host_address = a;
        host_writedata = d;
        host_byteenable = be;
        #2;
        chk("host_wait", host_waitrequest, 1'b0);
        chk("ram_cs", ram_chipselect, inr);
        chk("ram_write", ram_write, wr & inr);
        chk("ram_debug", ram_debugaccess, wr & inr);
        if (inr) chk("ram_addr", 32'(ram_address), 32'(a));
        if (wr) begin
            if (inr) shadow[a] = merge(shadow[a], d, be);
        end else begin
            host_q.push_back(inr ? shadow[a] : 32'h0);
        end
        tick();
    endtask

    // Response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (host_readdatavalid) begin
                if (host_q.size() == 0) chk("host_spurious_rvalid", host_readdatavalid, 1'b0);
                else chk("host_rdata", host_readdata, host_q.pop_front());
            end else begin
                chk("host_rdata_idle", host_readdata, 32'h0);
            end
            if (core_readdatavalid) begin
                if (core_q.size() == 0) chk("core_spurious_rvalid", core_readdatavalid, 1'b0);
                else chk("core_rdata", core_readdata, core_q.pop_front());
            end else begin
                chk("core_rdata_idle", core_readdata, 32'h0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 5120; i++) shadow[i] = pat(i);
        idle();
        host_address = '0;
        host_byteenable = 4'hF;
        host_writedata = '0;
        core_address = '0;
        tick();
        do_reset();

        // Both ports request from reset: core first, then alternate.
        for (int i = 0; i < 4; i++) begin
            host_read = 1'b1;
            host_address = 13'(16'h100 + i);
            core_read = 1'b1;
            core_address = 13'(16'h200 + i);
            #2;
            chk("rr_host_wait", host_waitrequest, (i % 2) == 0);
            chk("rr_core_wait", core_waitrequest, (i % 2) != 0);
            if ((i % 2) == 0) core_q.push_back(shadow[16'h200 + i]);
            else host_q.push_back(shadow[16'h100 + i]);
            tick();
        end
        idle();
        #2;
        chk("rr_stall", 32'(core_stall_cnt), 32'd2);
        tick();
        tick();

        // Host write then readback; core idle throughout.
        host_acc(1'b1, 13'h0010, 32'hCAFEF00D, 4'hF);
        host_acc(1'b0, 13'h0010, 32'h0, 4'hF);
        idle();
        tick();
        tick();

        // Partial write over all-ones, back-to-back reads.
        host_acc(1'b1, 13'h0020, 32'hFFFFFFFF, 4'hF);
        host_acc(1'b1, 13'h0020, 32'h11223344, 4'b0101);
        chk("merge_model", shadow[13'h0020], 32'hFF22FF44);
        host_acc(1'b0, 13'h0020, 32'h0, 4'hF);
        host_acc(1'b0, 13'h0010, 32'h0, 4'hF);
        idle();
        tick();
        tick();

        // Out-of-range core read and sticky error flag.
        core_read = 1'b1;
        core_address = 13'd5120;
        #2;
        chk("oor_core_wait", core_waitrequest, 1'b0);
        chk("oor_ram_cs", ram_chipselect, 1'b0);
        core_q.push_back(32'h0);
        tick();
        idle();
        #2;
        chk("oor_err_set", err_oor, 1'b1);
        tick();
        err_clear = 1'b1;
        host_acc(1'b1, 13'd5200, 32'h12345678, 4'hF);
        idle();
        #2;
        chk("oor_err_hold", err_oor, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        #2;
        chk("oor_err_clear", err_oor, 1'b0);
        tick();
        host_acc(1'b0, 13'd8000, 32'h0, 4'hF);
        idle();
        tick();
        tick();

        // Reset right after a core read is accepted: response must vanish.
        core_read = 1'b1;
        core_address = 13'h0050;
        #2;
        chk("rst_mid_core_wait", core_waitrequest, 1'b0);
        tick();
        do_reset();
        tick();
        tick();

        // Host lock starves the core while host proceeds every cycle.
        host_lock = 1'b1;
        core_read = 1'b1;
        core_address = 13'h0040;
        for (int i = 0; i < 10; i++) begin
            host_read = 1'b1;
            host_address = 13'(16'h300 + i);
            #2;
            chk("lock_core_wait", core_waitrequest, 1'b1);
            chk("lock_host_wait", host_waitrequest, 1'b0);
            host_q.push_back(shadow[16'h300 + i]);
            tick();
        end
        idle();
        #2;
        chk("lock_stall", 32'(core_stall_cnt), 32'd10);
        tick();
        tick();
        tick();

        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
